// File: rtl/riscv_mem_pkg.sv
// Address map, STATUS layout and RAM-region helper shared by the data-side
// responder of the single-cycle RV32I core.
package riscv_mem_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
  localparam logic [31:0] TXDATA_ADDR = MMIO_BASE + 32'h0000_0000;
  localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'h0000_0004;
  localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE + 32'h0000_0008;
  localparam logic [31:0] DROPS_ADDR  = MMIO_BASE + 32'h0000_000C;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 8;
  localparam int STATUS_COUNT_MSB = 15;

  localparam logic [15:0] DROPS_MAX = 16'hFFFF;

  // First byte address past the RAM region.
  function automatic logic [31:0] ram_limit(input int words);
    return 32'(words) << 2;
  endfunction

endpackage

// File: rtl/dmem_mmio_if.sv
// Core data port plus the TX byte stream, bundled as one bus; the master side
// is the core together with the downstream byte consumer.
interface dmem_mmio_if;

  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  TxData;
  logic        TxValid;
  logic        TxReady;

  modport master (
    output MemWrite,
    output Addr,
    output WriteData,
    output TxReady,
    input  ReadData,
    input  TxData,
    input  TxValid
  );

  modport slave (
    input  MemWrite,
    input  Addr,
    input  WriteData,
    input  TxReady,
    output ReadData,
    output TxData,
    output TxValid
  );

endinterface

// File: rtl/dmem_mmio_tx_fifo.sv
// Byte-wide circular FIFO feeding the TX stream; a push into a full FIFO with
// no simultaneous pop is discarded and flagged on the drop pulse.
module tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] cnt;
  logic          do_pop;
  logic          do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  assign count   = cnt;

  // Head is a pure register read, gated to zero when nothing is queued.
  assign head = empty ? 8'h00 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-side responder: word RAM plus an MMIO window with cycle counter,
// dropped-push counter and TX FIFO. Loads are combinational.
module dmem_mmio
  import riscv_mem_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  dmem_mmio_if.slave bus
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   word_addr;
  logic [1:0]    unused_addr_lo;
  logic [AW-1:0] ram_idx;
  logic          is_ram;
  logic          sel_tx;
  logic          sel_status;
  logic          sel_cycle;
  logic          sel_drops;

  logic [31:0]   cycle_cnt;
  logic [15:0]   drops_cnt;
  logic [31:0]   status_word;
  logic [31:0]   rdata;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          fifo_drop;

  // Word access only: the byte offset takes no part in decode.
  assign word_addr      = {bus.Addr[31:2], 2'b00};
  assign unused_addr_lo = bus.Addr[1:0];
  assign ram_idx        = bus.Addr[AW+1:2];

  assign is_ram     = (word_addr < ram_limit(RAM_WORDS));
  assign sel_tx     = (word_addr == TXDATA_ADDR);
  assign sel_status = (word_addr == STATUS_ADDR);
  assign sel_cycle  = (word_addr == CYCLE_ADDR);
  assign sel_drops  = (word_addr == DROPS_ADDR);

  assign fifo_push = bus.MemWrite & sel_tx;
  assign fifo_pop  = bus.TxReady & ~fifo_empty;

  tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (bus.WriteData[7:0]),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  assign bus.TxData  = fifo_head;
  assign bus.TxValid = ~fifo_empty;

  // RAM keeps its contents across reset; a same-cycle load sees the old word.
  always_ff @(posedge clk) begin
    if (bus.MemWrite && is_ram) begin
      ram[ram_idx] <= bus.WriteData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else if (bus.MemWrite && sel_cycle) begin
      cycle_cnt <= bus.WriteData;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // A clear wins over a drop landing on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drops_cnt <= '0;
    end else if (bus.MemWrite && sel_drops) begin
      drops_cnt <= '0;
    end else if (fifo_drop && (drops_cnt != DROPS_MAX)) begin
      drops_cnt <= drops_cnt + 16'd1;
    end
  end

  always_comb begin
    status_word                                    = '0;
    status_word[STATUS_EMPTY_BIT]                  = fifo_empty;
    status_word[STATUS_FULL_BIT]                   = fifo_full;
    status_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 8'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    if (is_ram) begin
      rdata = ram[ram_idx];
    end else if (sel_status) begin
      rdata = status_word;
    end else if (sel_cycle) begin
      rdata = cycle_cnt;
    end else if (sel_drops) begin
      rdata = {16'h0000, drops_cnt};
    end
  end

  assign bus.ReadData = rdata;

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: vector table for RAM/decode, a FIFO scoreboard checked
// every cycle, and directed sequences for fill/drain, counters and reset.
module tb_dmem_mmio;

  localparam int DEPTH = 8;
  localparam logic [31:0] A_TX     = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = 32'h8000_0004;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0008;
  localparam logic [31:0] A_DROPS  = 32'h8000_000C;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  int   mon_pops;
  bit   m_pop;
  bit   m_push;
  bit   m_full;
  logic [7:0] exp_q [$];

  dmem_mmio_if bus ();

  dmem_mmio #(
    .RAM_WORDS  (64),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite  = 1'b1;
    bus.Addr      = a;
    bus.WriteData = d;
    tick();
    bus.MemWrite  = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.Addr = a;
    #1;
    check(name, bus.ReadData, exp);
  endtask

  // Scoreboard: at each falling edge the outputs are compared with the model
  // queue, then the model applies the push/pop the coming rising edge will do.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
    end
    check("txvalid", 32'(bus.TxValid), 32'(exp_q.size() != 0));
    check("txdata", 32'(bus.TxData), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
    if (reset) begin
      m_full = (exp_q.size() == DEPTH);
      m_pop  = bus.TxReady && (exp_q.size() != 0);
      m_push = bus.MemWrite && ({bus.Addr[31:2], 2'b00} == A_TX);
      if (m_pop) begin
        void'(exp_q.pop_front());
        mon_pops++;
      end
      if (m_push && (!m_full || m_pop)) begin
        exp_q.push_back(bus.WriteData[7:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_tests);
    $fatal(1);
  end

  initial begin
    int c;
    int p0;
    n_tests  = 0;
    n_fail   = 0;
    mon_pops = 0;
    reset         = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.Addr      = '0;
    bus.WriteData = '0;
    bus.TxReady   = 1'b0;

    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vt[2]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vt[3]  = '{1'b0, 32'h8000_0100, 32'h0,         1'b1, 32'h0};
    vt[4]  = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF};
    vt[5]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hCAFE_F00D};
    vt[6]  = '{1'b1, 32'h0000_00FC, 32'h0BAD_CAFE, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 32'h0000_00FC, 32'h0,         1'b1, 32'h0BAD_CAFE};
    vt[8]  = '{1'b1, 32'h0000_0000, 32'h5555_AAAA, 1'b0, 32'h0};
    vt[9]  = '{1'b1, 32'h0000_0100, 32'h1111_1111, 1'b1, 32'h0};
    vt[10] = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h5555_AAAA};
    vt[11] = '{1'b0, A_STATUS,      32'h0,         1'b1, 32'h0000_0001};
    vt[12] = '{1'b0, A_DROPS,       32'h0,         1'b1, 32'h0};
    vt[13] = '{1'b0, A_TX,          32'h0,         1'b1, 32'h0};
    vt[14] = '{1'b1, A_STATUS,      32'hFFFF_FFFF, 1'b0, 32'h0};
    vt[15] = '{1'b0, A_STATUS,      32'h0,         1'b1, 32'h0000_0001};
    vt[16] = '{1'b0, 32'h8000_0010, 32'h0,         1'b1, 32'h0};

    // Reset state and release behaviour of CYCLE
    #2 reset = 1'b0;
    #1;
    check("rst_txvalid", 32'(bus.TxValid), 32'h0);
    check("rst_txdata", 32'(bus.TxData), 32'h0);
    rdchk("rst_cycle", A_CYCLE, 32'h0);
    tick();
    rdchk("rst_cycle_held", A_CYCLE, 32'h0);
    reset = 1'b1;
    rdchk("cycle_pre_edge", A_CYCLE, 32'h0);
    tick();
    rdchk("cycle_post_edge", A_CYCLE, 32'h1);

    // RAM and decode vectors
    for (int i = 0; i < 17; i++) begin
      bus.MemWrite  = vt[i].wr;
      bus.Addr      = vt[i].addr;
      bus.WriteData = vt[i].wdata;
      #1;
      if (vt[i].chk) check($sformatf("vec%0d", i), bus.ReadData, vt[i].exp);
      tick();
    end
    bus.MemWrite = 1'b0;

    // Fill past full with the consumer stalled, then drain in order
    for (int i = 0; i < 9; i++) wr(A_TX, 32'(8'h41 + i));
    rdchk("fill_status", A_STATUS, 32'h0000_0802);
    rdchk("fill_drops", A_DROPS, 32'h1);
    check("fill_head", 32'(bus.TxData), 32'h41);
    bus.TxReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("drain%0d", i), 32'(bus.TxData), 32'(8'h41 + i));
      tick();
    end
    bus.TxReady = 1'b0;
    check("drain_txvalid", 32'(bus.TxValid), 32'h0);
    rdchk("drain_status", A_STATUS, 32'h0000_0001);

    // Drop counting, clear, and push+pop on the same edge while full
    for (int i = 0; i < 8; i++) wr(A_TX, 32'(8'h61 + i));
    wr(A_TX, 32'h69);
    rdchk("drops_two", A_DROPS, 32'h2);
    wr(A_DROPS, 32'h1234);
    rdchk("drops_clr", A_DROPS, 32'h0);
    bus.TxReady = 1'b1;
    wr(A_TX, 32'h5A);
    bus.TxReady = 1'b0;
    rdchk("pp_full_status", A_STATUS, 32'h0000_0802);
    rdchk("pp_full_drops", A_DROPS, 32'h0);
    check("pp_full_head", 32'(bus.TxData), 32'h62);
    p0 = mon_pops;
    c  = 0;
    bus.TxReady = 1'b1;
    while (bus.TxValid && c < 20) begin
      if (c == 2) begin
        bus.MemWrite  = 1'b1;
        bus.Addr      = A_TX;
        bus.WriteData = 32'h77;
      end else begin
        bus.MemWrite = 1'b0;
      end
      tick();
      c++;
    end
    bus.MemWrite = 1'b0;
    bus.TxReady  = 1'b0;
    check("drain2_done", 32'(bus.TxValid), 32'h0);
    check("drain2_pops", 32'(mon_pops - p0), 32'd9);
    rdchk("drain2_status", A_STATUS, 32'h0000_0001);

    // CYCLE load and wrap
    wr(A_CYCLE, 32'hFFFF_FFFE);
    rdchk("cyc_load", A_CYCLE, 32'hFFFF_FFFE);
    tick();
    rdchk("cyc_max", A_CYCLE, 32'hFFFF_FFFF);
    tick();
    rdchk("cyc_wrap", A_CYCLE, 32'h0);

    // Reset asserted mid-drain with three bytes queued
    wr(32'h0000_0020, 32'h1357_2468);
    for (int i = 0; i < 9; i++) wr(A_TX, 32'(8'h31 + i));
    rdchk("pre_rst_drops", A_DROPS, 32'h1);
    bus.TxReady = 1'b1;
    repeat (5) tick();
    check("pre_rst_head", 32'(bus.TxData), 32'h36);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_txvalid", 32'(bus.TxValid), 32'h0);
    check("mid_rst_txdata", 32'(bus.TxData), 32'h0);
    rdchk("mid_rst_cycle", A_CYCLE, 32'h0);
    rdchk("mid_rst_status", A_STATUS, 32'h0000_0001);
    rdchk("mid_rst_drops", A_DROPS, 32'h0);
    rdchk("mid_rst_ram20", 32'h0000_0020, 32'h1357_2468);
    rdchk("mid_rst_ram10", 32'h0000_0010, 32'hCAFE_F00D);
    bus.TxReady = 1'b0;
    tick();
    reset = 1'b1;
    rdchk("rel_cycle0", A_CYCLE, 32'h0);
    tick();
    rdchk("rel_cycle1", A_CYCLE, 32'h1);
    check("rel_txvalid", 32'(bus.TxValid), 32'h0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side responder for the single-cycle RV32I core: it sits on the core's data port (`MemWrite`, address, `WriteData` in; `ReadData` out) and answers every load and store. It contains a word-addressed data RAM and a small MMIO window. The window holds a free-running cycle counter, a dropped-write counter, and an 8-bit transmit FIFO that is drained by an external valid/ready consumer. Reads are combinational so the core's loads complete in their own cycle. All state changes on the rising clock edge.

## Interface
- `RAM_WORDS`, default 64, number of 32-bit RAM words (power of two, at least 4).
- `FIFO_DEPTH`, default 8, number of TX FIFO entries (power of two, at least 2).
- `clk`  in  1  the single clock; everything is rising-edge triggered.
- `reset`  in  1  asynchronous, active-low reset.
- `MemWrite`  in  1  store strobe from the core.
- `Addr`  in  32  byte address, driven by the core's `ALUResult`.
- `WriteData`  in  32  store data from the core.
- `ReadData`  out  32  load data; combinational from `Addr`.
- `TxData`  out  8  FIFO head byte; reads 0 when the FIFO is empty.
- `TxValid`  out  1  FIFO not empty.
- `TxReady`  in  1  consumer accepts the head on a clock edge where `TxValid` is high.

## Operation
- Word access only: `Addr[1:0]` is ignored. No byte enables.
- Address decode:
  - `0x0000_0000` to `RAM_WORDS*4-1`: RAM, indexed by `Addr[log2(RAM_WORDS)+1:2]`.
  - `0x8000_0000` TXDATA: a write pushes `WriteData[7:0]`; a read returns 0.
  - `0x8000_0004` STATUS: read only.
    - bit0 = empty, bit1 = full.
    - bits[15:8] = occupancy count.
    - all other bits 0.
  - `0x8000_0008` CYCLE: a read returns the counter; a write loads `WriteData`.
  - `0x8000_000C` DROPS: a read returns the 16-bit dropped-push count, zero-extended; any write clears it.
- Unmapped addresses: a read returns 0; a write has no effect.
- RAM:
  - A store writes the full word at the edge.
  - RAM is not cleared by reset.
  - A load in the cycle of a store to the same address returns the old word.
- CYCLE:
  - Increments by 1 every cycle and wraps from `0xFFFF_FFFF` to 0.
  - On a CYCLE write edge the counter takes `WriteData` and does not increment that cycle.
- TX FIFO:
  - Circular buffer with read/write pointers and a count.
  - A pop happens on an edge where `TxValid` and `TxReady` are both high.
  - A push happens on a TXDATA write edge. If the FIFO is full and there is no pop on the same edge, the byte is discarded and DROPS increments, saturating at `0xFFFF`.
  - Push and pop on the same edge when full: both take effect, count unchanged, nothing dropped.
  - Push and pop on the same edge when neither full nor empty: both take effect, count unchanged.
  - Push when empty: no bypass. The byte appears on `TxData` one cycle after the write edge.
  - Pointers wrap modulo `FIFO_DEPTH`.
- DROPS: a clear (DROPS write) and a drop on the same edge leave DROPS at 0.
- Reset (asserted at any time, including mid-transfer):
  - FIFO emptied and its contents discarded.
  - `TxValid` = 0, `TxData` = 0.
  - CYCLE = 0, DROPS = 0.
  - `ReadData` still follows `Addr` combinationally (RAM contents; MMIO values in their reset state).
  - After reset is released, CYCLE reads 0 before the first rising edge and 1 after it.

## Timing
- Load latency is 0 cycles: `ReadData` settles in the same cycle as `Addr`.
- STATUS, CYCLE and DROPS reads return the values held before the current edge.
- Store, push, pop and counter updates become visible the cycle after the edge.
- `TxValid` and `TxData` come straight from registers; there is no combinational path from `TxReady` or `MemWrite`.
- Once `TxValid` is high, `TxData` stays stable until it is popped or reset asserts.

## Structure
- Package `riscv_mem_pkg` holds:
  - the address constants `MMIO_BASE`, `TXDATA_ADDR`, `STATUS_ADDR`, `CYCLE_ADDR`, `DROPS_ADDR`;
  - the STATUS bit positions;
  - the RAM region limit function.
- Sub-module `tx_fifo` (parameter `DEPTH`):
  - inputs: `push`, `push_data`, `pop`;
  - outputs: `head`, `empty`, `full`, `count`, and a `drop` pulse.
  - Top level holds the decode, the RAM, CYCLE, DROPS and the read mux.

## Test plan
- Reset, then store `0xDEADBEEF` to `0x10` → the next cycle a load of `0x10` (and of `0x13`) returns `0xDEADBEEF`; a load of `0x8000_0100` returns 0.
- Hold `TxReady`=0 and push bytes `0x41` to `0x49` (9 pushes) → STATUS = `0x0000_0802` (count 8, full), DROPS = 1, head = `0x41`.
- Then raise `TxReady` → bytes `0x41` to `0x48` drain in order, one per cycle; `TxValid` falls after the 8th pop; STATUS = `0x0000_0001`.
- FIFO full, push `0x5A` on the same edge as a pop → count stays 8, DROPS unchanged, `0x5A` appears last in the drain order.
- Write CYCLE = `0xFFFF_FFFE` → reads `0xFFFF_FFFE`, `0xFFFF_FFFF`, then 0 on successive cycles.
- Assert `reset` mid-drain with 3 bytes queued → `TxValid` and `TxData` are 0 immediately (asynchronously), CYCLE = 0, and RAM words written before reset read back unchanged.
